// File: rtl/apb_mem_slave.sv
// APB4 memory slave: DEPTH words of DATA_WIDTH bits, byte-lane writes,
// programmable wait states and PSLVERR on accesses beyond DEPTH.
module apb_mem_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    PCLK,
    input  logic                    RST,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    localparam int NB       = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_W:0] DEPTH_V = (IDX_W + 1)'(DEPTH);
    localparam logic [3:0]     WAIT_V  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           strb_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic                    pready_q, pslverr_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    capture, go_ready, drop_ready, complete;
    logic [IDX_W-1:0]        cur_idx;
    logic                    cur_wr, oor;
    logic [DATA_WIDTH-1:0]   rd_word;

    // Byte-offset bits of PADDR carry no information for a word memory.
    logic unused_paddr;
    assign unused_paddr = ^PADDR;

    // With zero wait states READY is entered on the setup edge itself, so the
    // response must be formed from the live bus rather than the captured copy.
    assign cur_idx = (state_q == S_IDLE) ? PADDR[ADDR_WIDTH-1:ADDR_LSB] : idx_q;
    assign cur_wr  = (state_q == S_IDLE) ? PWRITE : wr_q;
    assign oor     = ({1'b0, cur_idx} >= DEPTH_V);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++)
            if (cur_idx == IDX_W'(i)) rd_word = mem_q[i];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        go_ready   = 1'b0;
        drop_ready = 1'b0;
        complete   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = S_READY;
                        go_ready = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_V;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d  = S_READY;
                        go_ready = 1'b1;
                    end
                end
            end
            S_READY: begin
                state_d    = S_IDLE;
                drop_ready = 1'b1;
                complete   = PSEL && PENABLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q   <= PADDR[ADDR_WIDTH-1:ADDR_LSB];
                wr_q    <= PWRITE;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
            end
            if (go_ready) begin
                pready_q  <= 1'b1;
                pslverr_q <= oor;
                if (!cur_wr) prdata_q <= rd_word;
            end else if (drop_ready) begin
                pready_q  <= 1'b0;
                pslverr_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (complete && wr_q && !oor) begin
            for (int i = 0; i < DEPTH; i++)
                if (idx_q == IDX_W'(i))
                    for (int b = 0; b < NB; b++)
                        if (strb_q[b]) mem_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
endmodule
